// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the icache/dcache memory arbiter: bus widths,
// parameter defaults, FSM state and owner encodings.
package mem_arbiter_pkg;

    localparam int ADDR_W         = 32;
    localparam int DATA_W         = 32;
    localparam int STRB_W         = DATA_W / 8;
    localparam int STARVE_MAX_DEF = 4;
    localparam int LEN_W_DEF      = 3;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ADDR  = 3'd1,
        ST_RDATA = 3'd2,
        ST_WDATA = 3'd3,
        ST_WRESP = 3'd4
    } arb_state_e;

    typedef enum logic {
        OWN_IC = 1'b0,
        OWN_DC = 1'b1
    } owner_e;

endpackage

// File: rtl/mem_arbiter_if.sv
// Bundle of the icache, dcache and memory-side signals around the arbiter.
// The arbiter takes the slave view; requesters and memory take the master view.
interface mem_arbiter_if import mem_arbiter_pkg::*; #(
    parameter int LEN_W = LEN_W_DEF
);
    logic              ic_req;
    logic [ADDR_W-1:0] ic_addr;
    logic [LEN_W-1:0]  ic_len;
    logic              ic_gnt;
    logic              ic_rvalid;
    logic [DATA_W-1:0] ic_rdata;
    logic              ic_done;

    logic              dc_req;
    logic              dc_wr;
    logic [ADDR_W-1:0] dc_addr;
    logic [LEN_W-1:0]  dc_len;
    logic [DATA_W-1:0] dc_wdata;
    logic [STRB_W-1:0] dc_wstrb;
    logic              dc_gnt;
    logic              dc_rvalid;
    logic [DATA_W-1:0] dc_rdata;
    logic              dc_wnext;
    logic              dc_done;

    logic              mem_req;
    logic              mem_wr;
    logic [ADDR_W-1:0] mem_addr;
    logic [LEN_W-1:0]  mem_len;
    logic              mem_ack;
    logic [DATA_W-1:0] mem_wdata;
    logic [STRB_W-1:0] mem_wstrb;
    logic              mem_wvalid;
    logic              mem_wlast;
    logic              mem_wready;
    logic              mem_bvalid;
    logic              mem_rvalid;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_rlast;

    logic              ic_busy;
    logic              dc_busy;
    logic              err;

    modport slave (
        input  ic_req, ic_addr, ic_len,
        output ic_gnt, ic_rvalid, ic_rdata, ic_done,
        input  dc_req, dc_wr, dc_addr, dc_len, dc_wdata, dc_wstrb,
        output dc_gnt, dc_rvalid, dc_rdata, dc_wnext, dc_done,
        output mem_req, mem_wr, mem_addr, mem_len,
        input  mem_ack,
        output mem_wdata, mem_wstrb, mem_wvalid, mem_wlast,
        input  mem_wready, mem_bvalid, mem_rvalid, mem_rdata, mem_rlast,
        output ic_busy, dc_busy, err
    );

    modport master (
        output ic_req, ic_addr, ic_len,
        input  ic_gnt, ic_rvalid, ic_rdata, ic_done,
        output dc_req, dc_wr, dc_addr, dc_len, dc_wdata, dc_wstrb,
        input  dc_gnt, dc_rvalid, dc_rdata, dc_wnext, dc_done,
        input  mem_req, mem_wr, mem_addr, mem_len,
        output mem_ack,
        input  mem_wdata, mem_wstrb, mem_wvalid, mem_wlast,
        output mem_wready, mem_bvalid, mem_rvalid, mem_rdata, mem_rlast,
        input  ic_busy, dc_busy, err
    );

endinterface

// File: rtl/mem_arbiter.sv
// Two-requester (icache/dcache) arbiter onto a single-outstanding burst memory
// port. dcache has priority unless it has starved a pending icache request.
module mem_arbiter import mem_arbiter_pkg::*; #(
    parameter int STARVE_MAX = STARVE_MAX_DEF,
    parameter int LEN_W      = LEN_W_DEF
) (
    input  logic         clk,
    input  logic         resetn,
    mem_arbiter_if.slave bus
);

    localparam int            SW         = $clog2(STARVE_MAX + 1);
    localparam logic [SW-1:0] STREAK_SAT = SW'(STARVE_MAX);

    arb_state_e        state;
    owner_e            owner;
    logic              wr_q;
    logic              err_q;
    logic [ADDR_W-1:0] addr_q;
    logic [LEN_W-1:0]  len_q;
    logic [LEN_W-1:0]  beat;
    logic [SW-1:0]     streak;

    logic idle, ic_win, dc_win, last_beat, rd_beat, wr_beat;

    assign idle      = (state == ST_IDLE);
    assign ic_win    = idle && bus.ic_req && (!bus.dc_req || streak == STREAK_SAT);
    assign dc_win    = idle && bus.dc_req && !ic_win;
    assign last_beat = (beat == len_q);
    assign rd_beat   = (state == ST_RDATA) && bus.mem_rvalid;
    assign wr_beat   = (state == ST_WDATA) && bus.mem_wready;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state  <= ST_IDLE;
            owner  <= OWN_IC;
            wr_q   <= 1'b0;
            addr_q <= '0;
            len_q  <= '0;
            beat   <= '0;
            streak <= '0;
            err_q  <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    beat <= '0;
                    if (ic_win) begin
                        owner  <= OWN_IC;
                        wr_q   <= 1'b0;
                        addr_q <= bus.ic_addr;
                        len_q  <= bus.ic_len;
                        state  <= ST_ADDR;
                    end else if (dc_win) begin
                        owner  <= OWN_DC;
                        wr_q   <= bus.dc_wr;
                        addr_q <= bus.dc_addr;
                        len_q  <= bus.dc_len;
                        state  <= ST_ADDR;
                    end
                    // Streak only measures dcache wins against a waiting icache.
                    if (ic_win || !bus.ic_req)
                        streak <= '0;
                    else if (dc_win && streak != STREAK_SAT)
                        streak <= streak + 1'b1;
                end
                ST_ADDR: begin
                    if (bus.mem_ack)
                        state <= wr_q ? ST_WDATA : ST_RDATA;
                end
                ST_RDATA: begin
                    if (bus.mem_rvalid) begin
                        // The local beat count is authoritative; rlast is only checked.
                        if (bus.mem_rlast != last_beat)
                            err_q <= 1'b1;
                        if (last_beat) begin
                            beat  <= '0;
                            state <= ST_IDLE;
                        end else begin
                            beat <= beat + 1'b1;
                        end
                    end
                end
                ST_WDATA: begin
                    if (bus.mem_wready) begin
                        if (last_beat) begin
                            beat  <= '0;
                            state <= ST_WRESP;
                        end else begin
                            beat <= beat + 1'b1;
                        end
                    end
                end
                ST_WRESP: begin
                    if (bus.mem_bvalid)
                        state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Grants and busy depend on live request inputs, so they are masked in reset;
    // everything else derives from state and clears with it.
    assign bus.ic_gnt    = resetn && ic_win;
    assign bus.dc_gnt    = resetn && dc_win;
    assign bus.ic_busy   = resetn && (bus.ic_req || (owner == OWN_IC && !idle));
    assign bus.dc_busy   = resetn && (bus.dc_req || (owner == OWN_DC && !idle));

    assign bus.ic_rvalid = rd_beat && (owner == OWN_IC);
    assign bus.dc_rvalid = rd_beat && (owner == OWN_DC);
    assign bus.ic_rdata  = bus.ic_rvalid ? bus.mem_rdata : '0;
    assign bus.dc_rdata  = bus.dc_rvalid ? bus.mem_rdata : '0;
    assign bus.ic_done   = bus.ic_rvalid && last_beat;
    assign bus.dc_done   = (bus.dc_rvalid && last_beat) ||
                           ((state == ST_WRESP) && bus.mem_bvalid && (owner == OWN_DC));
    assign bus.dc_wnext  = wr_beat && (owner == OWN_DC);

    assign bus.mem_req    = (state == ST_ADDR);
    assign bus.mem_wr     = bus.mem_req && wr_q;
    assign bus.mem_addr   = bus.mem_req ? addr_q : '0;
    assign bus.mem_len    = bus.mem_req ? len_q : '0;
    assign bus.mem_wvalid = (state == ST_WDATA);
    assign bus.mem_wdata  = bus.mem_wvalid ? bus.dc_wdata : '0;
    assign bus.mem_wstrb  = bus.mem_wvalid ? bus.dc_wstrb : '0;
    assign bus.mem_wlast  = bus.mem_wvalid && last_beat;

    assign bus.err = err_q;

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter STARVE_MAX, default 4, SHALL set the consecutive dcache grants allowed while ic_req is pending.
REQ-002 Parameter LEN_W, default 3, SHALL set the width of burst length fields (beats-1).
REQ-003 clk  in  1  sole clock; all state SHALL update on rising edge.
REQ-004 resetn  in  1  reset: one clock; reset is asynchronous and active-low.
REQ-005 ic_req in 1, ic_addr in 32, ic_len in LEN_W: icache refill request (read only).
REQ-006 ic_gnt out 1, ic_rvalid out 1, ic_rdata out 32, ic_done out 1: icache grant pulse, read beat, data, final-beat pulse.
REQ-007 dc_req in 1, dc_wr in 1, dc_addr in 32, dc_len in LEN_W, dc_wdata in 32, dc_wstrb in 4: dcache request (read or write).
REQ-008 dc_gnt out 1, dc_rvalid out 1, dc_rdata out 32, dc_wnext out 1, dc_done out 1: grant, read beat, data, write-word consumed, completion.
REQ-009 mem_req out 1, mem_wr out 1, mem_addr out 32, mem_len out LEN_W, mem_ack in 1: memory address phase.
REQ-010 mem_wdata out 32, mem_wstrb out 4, mem_wvalid out 1, mem_wlast out 1, mem_wready in 1, mem_bvalid in 1: write data/response.
REQ-011 mem_rvalid in 1, mem_rdata in 32, mem_rlast in 1: read data.
REQ-012 ic_busy out 1, dc_busy out 1: requester has pending/active transaction, fed to ctrl stallreq_from_ic/stallreq_from_dc; err out 1: sticky protocol error.

Function
REQ-013 FSM states SHALL be IDLE, ADDR, RDATA, WDATA, WRESP; only one transaction outstanding.
REQ-014 In IDLE, arbitration SHALL be evaluated each cycle: dc wins over ic, except ic wins when ic_req=1 and streak==STARVE_MAX.
REQ-015 On a grant, addr/len/wr/owner SHALL be latched, the matching gnt SHALL pulse one cycle, FSM -> ADDR next cycle.
REQ-016 Streak counter SHALL increment on dc grant while ic_req=1, saturate at STARVE_MAX, clear on ic grant or when ic_req=0 in IDLE.
REQ-017 Requesters SHALL hold req/addr/len/wr stable until gnt; arbiter samples them only in IDLE.
REQ-018 ADDR: mem_req=1 with latched fields until mem_ack=1; then -> RDATA if read, WDATA if write.
REQ-019 RDATA: mem_rvalid/mem_rdata SHALL pass combinationally to owner's rvalid/rdata (zero latency); beat counter increments per beat.
REQ-020 Beat with counter==len SHALL pulse owner's done and -> IDLE; mem_rlast mismatching counter==len SHALL set err, still end on counter==len.
REQ-021 WDATA: mem_wvalid=1, mem_wdata/wstrb = dc_wdata/dc_wstrb; each cycle with mem_wready=1 SHALL pulse dc_wnext and count a beat; mem_wlast=1 when counter==len.
REQ-022 After last write beat -> WRESP; mem_bvalid=1 SHALL pulse dc_done and -> IDLE.
REQ-023 Earliest re-grant SHALL be the cycle after done (IDLE evaluated then).
REQ-024 xx_busy SHALL be xx_req OR (owner==xx and FSM!=IDLE).
REQ-025 Non-owner rvalid/done/wnext SHALL be 0; rdata outputs SHALL be 0 when rvalid=0.

Reset
REQ-026 resetn=0 SHALL immediately force IDLE, counters 0, streak 0, err 0, all outputs 0, regardless of transaction in flight.
REQ-027 After resetn deasserts, arbitration SHALL resume on the first rising edge; abandoned memory transactions are not completed.

Structure
REQ-028 FSM state encoding, STARVE_MAX and LEN_W defaults SHALL live in the shared defines header alongside existing bus widths.
REQ-029 Single module; no sub-module, beat and streak counters inline.

Verification
REQ-030 ic_req only, addr 0x1FC0_0000, len 3; memory returns 4 beats 1 cycle apart -> 4 ic_rvalid, ic_done on 4th, ic_busy low after.
REQ-031 ic_req and dc_req (read, len 0) same cycle -> dc_gnt first; ic_gnt cycle after dc_done.
REQ-032 dc_req held continuously with ic_req, STARVE_MAX=4 -> 4 dc grants then ic_gnt, streak 0.
REQ-033 dc write len 1, mem_wready low 2 cycles then high -> 2 dc_wnext pulses, mem_wlast on 2nd, dc_done on mem_bvalid.
REQ-034 mem_rlast on beat 2 of len 3 read -> err=1 sticky, done on beat 4.
REQ-035 resetn low during RDATA beat 2 -> all outputs 0 same cycle, IDLE; fresh ic request completes normally.
